// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared width default, ALU opcode and arbiter FSM state types
package alu_arb_pkg;

   localparam int ALU_ARB_WIDTH = 16;

   typedef enum logic [1:0] {
      ADD  = 2'b00,
      SUB  = 2'b01,
      AND  = 2'b10,
      NOTB = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } arb_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: add, subtract, AND, NOT-B, with zero flag
module alu
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = ALU_ARB_WIDTH
) (
   input  logic [WIDTH-1:0] Ain,
   input  logic [WIDTH-1:0] Bin,
   input  alu_op_e          ALUop,
   output logic [WIDTH-1:0] out,
   output logic             Z
);

   always_comb begin
      out = '0;
      case (ALUop)
         ADD:     out = Ain + Bin;
         SUB:     out = Ain - Bin;
         AND:     out = Ain & Bin;
         NOTB:    out = ~Bin;
         default: out = '0;
      endcase
   end

   assign Z = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one ALU
// Optional flags rsp_n/rsp_v are built when ALU_ARB_FLAGS_EN is defined.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = ALU_ARB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_z
`ifdef ALU_ARB_FLAGS_EN
   ,
   output logic             rsp_n,
   output logic             rsp_v
`endif
);

   arb_state_e       state, state_next;
   logic             last_grant;
   logic             grant;
   logic             accept;
   logic [WIDTH-1:0] cap_a, cap_b;
   alu_op_e          cap_op;
   logic             cap_id;
   logic [WIDTH-1:0] alu_out;
   logic             alu_z;

   // On a tie the requester that did not win last time is chosen.
   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      case (state)
         IDLE: begin
            if (rst_n && (req0_valid || req1_valid)) begin
               accept     = 1'b1;
               req0_ready = ~grant;
               req1_ready = grant;
               state_next = EXEC;
            end
         end
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cap_a      <= '0;
         cap_b      <= '0;
         cap_op     <= ADD;
         cap_id     <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            last_grant <= grant;
            cap_id     <= grant;
            cap_a      <= grant ? req1_a : req0_a;
            cap_b      <= grant ? req1_b : req0_b;
            cap_op     <= alu_op_e'(grant ? req1_op : req0_op);
         end
      end
   end

   alu #(.WIDTH(WIDTH)) u_alu (
      .Ain   (cap_a),
      .Bin   (cap_b),
      .ALUop (cap_op),
      .out   (alu_out),
      .Z     (alu_z)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data <= '0;
         rsp_z    <= 1'b0;
         rsp_id   <= 1'b0;
      end else if (state == EXEC) begin
         rsp_data <= alu_out;
         rsp_z    <= alu_z;
         rsp_id   <= cap_id;
      end
   end

`ifdef ALU_ARB_FLAGS_EN
   logic sign_a, sign_b, sign_r, ovf;

   assign sign_a = cap_a[WIDTH-1];
   assign sign_b = cap_b[WIDTH-1];
   assign sign_r = alu_out[WIDTH-1];

   always_comb begin
      ovf = 1'b0;
      case (cap_op)
         ADD:     ovf = (sign_a == sign_b) && (sign_r != sign_a);
         SUB:     ovf = (sign_a != sign_b) && (sign_r != sign_a);
         default: ovf = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_n <= 1'b0;
         rsp_v <= 1'b0;
      end else if (state == EXEC) begin
         rsp_n <= sign_r;
         rsp_v <= ovf;
      end
   end
`endif

   assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a response scoreboard
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
   logic         rsp_valid, rsp_id, rsp_z;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_data;
`ifdef ALU_ARB_FLAGS_EN
   logic         rsp_n, rsp_v;
`endif

   typedef struct {
      logic         id;
      logic [W-1:0] data;
      logic         z;
   } exp_t;

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic [W-1:0] ed;
      logic         ez;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[8];
   int   vec_count = 0;
   int   miss_count = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_z      (rsp_z)
`ifdef ALU_ARB_FLAGS_EN
      ,
      .rsp_n      (rsp_n),
      .rsp_v      (rsp_v)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         miss_count++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op);
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      end
   endtask

   // Starts and ends at a falling edge; the request is accepted on the next rising edge.
   task automatic issue(input string name, input logic id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] op,
                        input logic [W-1:0] ed, input logic ez);
      bit ok = 1'b0;
      drive(id, a, b, op);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (id ? req1_ready : req0_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({name, " grant"}, 32'(ok), 32'd1);
      if (ok) sb.push_back('{id, ed, ez});
      @(posedge clk);
      #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic collect(input string name);
      bit   ok;
      exp_t e;
      wait_rsp(ok);
      check({name, " rsp_valid timeout"}, 32'(ok), 32'd1);
      if (!ok) return;
      if (sb.size() == 0) begin
         check({name, " unexpected response"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({name, " rsp_id"}, 32'(rsp_id), 32'(e.id));
         check({name, " rsp_data"}, 32'(rsp_data), 32'(e.data));
         check({name, " rsp_z"}, 32'(rsp_z), 32'(e.z));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   ok, seen;
      exp_t e;

      tbl[0] = '{1'b0, 16'd17,    16'd29,    2'b00, 16'd46,    1'b0};
      tbl[1] = '{1'b1, 16'h2000,  16'h2000,  2'b11, 16'hDFFF,  1'b0};
      tbl[2] = '{1'b0, 16'hFFFF,  16'h0001,  2'b00, 16'h0000,  1'b1};
      tbl[3] = '{1'b1, 16'd5,     16'd2,     2'b01, 16'd3,     1'b0};
      tbl[4] = '{1'b0, 16'h0000,  16'hFFFF,  2'b10, 16'h0000,  1'b1};
      tbl[5] = '{1'b1, 16'h1234,  16'h0FF0,  2'b10, 16'h0230,  1'b0};
      tbl[6] = '{1'b0, 16'h0000,  16'h0001,  2'b01, 16'hFFFF,  1'b0};
      tbl[7] = '{1'b1, 16'h1234,  16'hFFFF,  2'b11, 16'h0000,  1'b1};

      // reset state, with both requesters asserting valid
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_data", 32'(rsp_data), 32'd0);
      check("reset rsp_z/id", {30'd0, rsp_z, rsp_id}, 32'd0);
      check("reset readys", {30'd0, req0_ready, req1_ready}, 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // first add after reset, with exact latency
      issue("add17_29", 1'b0, 16'd17, 16'd29, 2'b00, 16'd46, 1'b0);
      check("latency exec rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("latency resp rsp_valid", 32'(rsp_valid), 32'd1);
      collect("add17_29");

      // table of single-requester operations
      for (int i = 0; i < 8; i++) begin
         issue($sformatf("vec%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op,
               tbl[i].ed, tbl[i].ez);
         collect($sformatf("vec%0d", i));
      end

      // simultaneous requests right after reset: requester 0 first
      do_reset();
      drive(1'b0, 16'd5, 16'd2, 2'b01);
      drive(1'b1, 16'h0000, 16'hFFFF, 2'b10);
      #1;
      check("tie req0_ready", 32'(req0_ready), 32'd1);
      check("tie req1_ready", 32'(req1_ready), 32'd0);
      sb.push_back('{1'b0, 16'd3, 1'b0});
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      check("tie exec readys", {30'd0, req0_ready, req1_ready}, 32'd0);
      collect("tie first");
      #1;
      check("tie second req1_ready", 32'(req1_ready), 32'd1);
      sb.push_back('{1'b1, 16'h0000, 1'b1});
      @(posedge clk);
      #1 req1_valid = 1'b0;
      @(negedge clk);
      collect("tie second");

      // response held with rsp_ready low for four cycles
      issue("hold", 1'b1, 16'hAAAA, 16'h5555, 2'b00, 16'hFFFF, 1'b0);
      wait_rsp(ok);
      check("hold rsp_valid", 32'(ok), 32'd1);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("hold cycle%0d", i),
               {13'd0, rsp_valid, rsp_data, req0_ready, req1_ready},
               {13'd0, 1'b1, 16'hFFFF, 1'b0, 1'b0});
      end
      if (sb.size() != 0) e = sb.pop_front();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hold release rsp_valid", 32'(rsp_valid), 32'd0);
      check("hold release idle", 32'(req0_ready | req1_ready), 32'd1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      @(negedge clk);

      // reset during EXEC discards the operation
      do_reset();
      issue("rst_exec", 1'b0, 16'd1, 16'd1, 2'b00, 16'd2, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_exec rsp_valid", 32'(rsp_valid), 32'd0);
      req0_valid = 1'b1;
      #1;
      check("rst_exec req0_ready", 32'(req0_ready), 32'd0);
      req0_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      check("rst_exec no response", 32'(seen), 32'd0);
      drive(1'b0, 16'h0100, 16'h0023, 2'b00);
      drive(1'b1, 16'h00F0, 16'h0F0F, 2'b10);
      #1;
      check("post-rst tie", {30'd0, req0_ready, req1_ready}, 32'd2);
      sb.push_back('{1'b0, 16'h0123, 1'b0});
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      collect("post-rst req0");
      req0_valid = 1'b1;
      #1;
      check("round robin tie", {30'd0, req0_ready, req1_ready}, 32'd1);
      sb.push_back('{1'b1, 16'h0000, 1'b1});
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      collect("round robin req1");

`ifdef ALU_ARB_FLAGS_EN
      issue("flag add", 1'b0, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0);
      wait_rsp(ok);
      check("flag add n/v", {30'd0, rsp_n, rsp_v}, 32'd3);
      collect("flag add");
      issue("flag sub", 1'b1, 16'h0003, 16'h0005, 2'b01, 16'hFFFE, 1'b0);
      wait_rsp(ok);
      check("flag sub n/v", {30'd0, rsp_n, rsp_v}, 32'd2);
      collect("flag sub");
`endif

      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
